// File: rtl/awg_seq_ctrl.sv
// awg_seq_ctrl: command-driven configuration sequencer for the two-channel
// signal generator. A valid/ready command port loads a shadow copy of the
// command; every generator-facing output is updated on one commit edge so the
// generator never sees a partially applied configuration. An automatic
// frequency-code sweep steps state_freq every DWELL_CYCLES clocks.
//
// Optional feature macro: SWEEP_PINGPONG_EN
//   defined   - sweep bounces lo..hi..lo (endpoints held one dwell each)
//   undefined - sweep wraps hi -> lo; no direction register exists
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op[2:0]           opcode
//   cmd_arg[11:0]         opcode argument
//   state[2:0]            wave select (7 = off)
//   state_freq[11:0]      frequency code, [11:4] tied to 0
//   state_amp[3:0]        amplitude code
//   state_phase[7:0]      channel-B phase code
//   sweep_active          sweep running
//   err                   one-cycle pulse on a rejected command
module awg_seq_ctrl #(
  parameter int unsigned DWELL_W      = 32,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [11:0] cmd_arg,
  output logic [2:0]  state,
  output logic [11:0] state_freq,
  output logic [3:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic        sweep_active,
  output logic        err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  localparam logic [2:0] OP_SET_WAVE  = 3'd0;
  localparam logic [2:0] OP_SET_FREQ  = 3'd1;
  localparam logic [2:0] OP_SET_AMP   = 3'd2;
  localparam logic [2:0] OP_SET_PHASE = 3'd3;
  localparam logic [2:0] OP_SWEEP     = 3'd4;
  localparam logic [2:0] OP_STOP      = 3'd5;
  localparam logic [2:0] OP_MUTE      = 3'd6;
  localparam logic [2:0] OP_UNMUTE    = 3'd7;

  localparam logic [2:0] WAVE_OFF = 3'd7;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  // Registered state
  logic [0:0]         fsm_q, fsm_d;
  logic [2:0]         op_q;
  logic [7:0]         arg_q;
  logic [2:0]         saved_q, saved_d;
  logic [3:0]         freq_q, freq_d;
  logic [3:0]         lo_q, lo_d, hi_q, hi_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [2:0]         state_d;
  logic [3:0]         amp_d;
  logic [7:0]         phase_d;
  logic               active_d, err_d;
`ifdef SWEEP_PINGPONG_EN
  logic               down_q, down_d;
`endif

  // Argument bits [11:8] carry no meaning for any opcode
  logic unused_arg_c;
  assign unused_arg_c = ^cmd_arg[11:8];

  // Argument field decode from the shadow copy
  logic [2:0] wave_arg_c;
  logic [3:0] lo_arg_c, hi_arg_c;
  logic       freq_ok_c, sweep_ok_c, commit_c, halt_c;

  assign wave_arg_c = arg_q[2:0];
  assign lo_arg_c   = arg_q[3:0];
  assign hi_arg_c   = arg_q[7:4];
  assign freq_ok_c  = (lo_arg_c >= 4'd1) && (lo_arg_c <= 4'd6);
  assign sweep_ok_c = (lo_arg_c >= 4'd1) && (lo_arg_c < hi_arg_c) && (hi_arg_c <= 4'd6);
  assign commit_c   = (fsm_q == ST_COMMIT);
  // Legal commands that own state_freq override a coincident sweep step
  assign halt_c     = commit_c && (((op_q == OP_SET_FREQ) && freq_ok_c) ||
                                   ((op_q == OP_SWEEP) && sweep_ok_c) ||
                                   (op_q == OP_STOP));

  assign state_freq = {8'd0, freq_q};

  // Next-state logic: command FSM, sweep stepping, then command commit
  always_comb begin
    fsm_d    = fsm_q;
    saved_d  = saved_q;
    freq_d   = freq_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    state_d  = state;
    amp_d    = state_amp;
    phase_d  = state_phase;
    active_d = sweep_active;
    err_d    = 1'b0;
`ifdef SWEEP_PINGPONG_EN
    down_d   = down_q;
`endif

    case (fsm_q)
      ST_IDLE:   if (cmd_valid) fsm_d = ST_COMMIT;
      ST_COMMIT: fsm_d = ST_IDLE;
      default:   fsm_d = ST_IDLE;
    endcase

    if (sweep_active && !halt_c) begin
      if (cnt_q == DWELL_LAST) begin
        cnt_d = '0;
`ifdef SWEEP_PINGPONG_EN
        if (!down_q) begin
          if (freq_q == hi_q) begin
            down_d = 1'b1;
            freq_d = freq_q - 4'd1;
          end else begin
            freq_d = freq_q + 4'd1;
          end
        end else begin
          if (freq_q == lo_q) begin
            down_d = 1'b0;
            freq_d = freq_q + 4'd1;
          end else begin
            freq_d = freq_q - 4'd1;
          end
        end
`else
        freq_d = (freq_q == hi_q) ? lo_q : freq_q + 4'd1;
`endif
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end

    if (commit_c) begin
      case (op_q)
        OP_SET_WAVE: begin
          if ((wave_arg_c == 3'd5) || (wave_arg_c == 3'd6)) begin
            err_d = 1'b1;
          end else begin
            state_d = wave_arg_c;
            if (wave_arg_c != WAVE_OFF) saved_d = wave_arg_c;
          end
        end
        OP_SET_FREQ: begin
          if (freq_ok_c) begin
            freq_d   = lo_arg_c;
            active_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_SET_AMP:   amp_d   = arg_q[3:0];
        OP_SET_PHASE: phase_d = arg_q;
        OP_SWEEP: begin
          if (sweep_ok_c) begin
            freq_d   = lo_arg_c;
            lo_d     = lo_arg_c;
            hi_d     = hi_arg_c;
            cnt_d    = '0;
            active_d = 1'b1;
`ifdef SWEEP_PINGPONG_EN
            down_d   = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        OP_STOP: begin
          active_d = 1'b0;
          freq_d   = freq_q;
        end
        OP_MUTE:   state_d = WAVE_OFF;
        OP_UNMUTE: state_d = saved_q;
        default:   ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= ST_IDLE;
      op_q         <= 3'd0;
      arg_q        <= 8'd0;
      saved_q      <= 3'd0;
      freq_q       <= 4'd1;
      lo_q         <= 4'd1;
      hi_q         <= 4'd1;
      cnt_q        <= '0;
      state        <= WAVE_OFF;
      state_amp    <= 4'd0;
      state_phase  <= 8'd0;
      sweep_active <= 1'b0;
      err          <= 1'b0;
      cmd_ready    <= 1'b1;
`ifdef SWEEP_PINGPONG_EN
      down_q       <= 1'b0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      if (cmd_valid && cmd_ready) begin
        op_q  <= cmd_op;
        arg_q <= cmd_arg[7:0];
      end
      saved_q      <= saved_d;
      freq_q       <= freq_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      cnt_q        <= cnt_d;
      state        <= state_d;
      state_amp    <= amp_d;
      state_phase  <= phase_d;
      sweep_active <= active_d;
      err          <= err_d;
      cmd_ready    <= (fsm_d == ST_IDLE);
`ifdef SWEEP_PINGPONG_EN
      down_q       <= down_d;
`endif
    end
  end

endmodule
